// File: rtl/psk_pkg.sv
// Shared types and constants for the PSK frame transceiver.
// Receiver state encoding, QPSK Gray-map phase quarters and sine-ROM initialisation.
package psk_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT
    } rx_state_e;

    // Phase offsets in quarter periods, indexed by pair value {b[2i+1], b[2i]}
    localparam int QPSK_Q00 = 0;
    localparam int QPSK_Q01 = 1;
    localparam int QPSK_Q11 = 2;
    localparam int QPSK_Q10 = 3;

    localparam real PI = 3.14159265358979;

    // round((2^(dw-1)-1) * sin(2*pi*k/n)), Taylor series on an angle folded into [-pi, pi]
    function automatic int sine_value(int k, int n, int dw);
        real x;
        real term;
        real s;
        real v;
        int  r;
        x = 2.0 * PI * real'(k) / real'(n);
        if (x > PI) x = x - 2.0 * PI;
        term = x;
        s    = x;
        for (int i = 1; i < 12; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        v = real'((1 << (dw - 1)) - 1) * s;
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        return r;
    endfunction

endpackage

// File: rtl/psk_frame_transceiver_if.sv
// Serial-in / modulated-out signal bundle for psk_frame_transceiver.
interface psk_frame_transceiver_if #(
    parameter int DATA_WIDTH = 12
);
    logic                         in;
    logic                         en;
    logic                         mode;
    logic                         done;
    logic                         err;
    logic                         overflow;
    logic                         busy;
    logic signed [DATA_WIDTH-1:0] signal_out;

    modport master (
        output in, en, mode,
        input  done, err, overflow, busy, signal_out
    );

    modport slave (
        input  in, en, mode,
        output done, err, overflow, busy, signal_out
    );
endinterface

// File: rtl/psk_sine_rom.sv
// One-period sine table with a registered read port; output forced to zero when not enabled.
module psk_sine_rom
    import psk_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int N          = 16,
    localparam int AW        = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [AW-1:0]                addr,
    output logic signed [DATA_WIDTH-1:0] data
);
    logic signed [DATA_WIDTH-1:0] rom [N];
    logic signed [DATA_WIDTH-1:0] data_d;
    logic signed [DATA_WIDTH-1:0] data_q;

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam int V = sine_value(k, N, DATA_WIDTH);
        assign rom[k] = DATA_WIDTH'(V);
    end

    always_comb begin
        data_d = '0;
        if (en) data_d = rom[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign data = data_q;
endmodule

// File: rtl/psk_frame_transceiver.sv
// Framed serial byte receiver with parity/stop checking, a small byte FIFO,
// and a BPSK/QPSK sine modulator draining the FIFO back-to-back.
module psk_frame_transceiver
    import psk_pkg::*;
#(
    parameter int DATA_WIDTH         = 12,
    parameter int BYTE_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter int SAMPLES_PER_SYMBOL = 16,
    parameter int PARITY_EN          = 1
) (
    input logic                     clk,
    input logic                     arst,
    psk_frame_transceiver_if.slave  bus
);
    localparam int N   = SAMPLES_PER_SYMBOL;
    localparam int SW  = $clog2(N);
    localparam int BCW = $clog2(BYTE_WIDTH);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    rx_state_e               rx_state_q, rx_state_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_WIDTH-1:0]   rx_byte_q, rx_byte_d;
    logic                    par_q, par_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [BYTE_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [BYTE_WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    empty_q, empty_d, full_q, full_d;

    logic                    active_q, active_d;
    logic [SW-1:0]           k_q, k_d;
    logic [BCW-1:0]          sym_q, sym_d, sym_last;
    logic [BYTE_WIDTH-1:0]   mod_byte_q, mod_byte_d;
    logic                    mode_q, mode_d;

    logic                    push, pop, last_sample, frame_ok;
    logic [1:0]              qtr;
    logic [SW-1:0]           offset, rom_addr;

    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_byte_d  = rx_byte_q;
        par_d      = par_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        frame_ok   = bus.in && ((PARITY_EN == 0) || !(^{rx_byte_q, par_q}));
        case (rx_state_q)
            RX_IDLE: if (!bus.in) begin
                rx_state_d = RX_DATA;
                bit_cnt_d  = '0;
            end
            RX_DATA: begin
                rx_byte_d = {bus.in, rx_byte_q[BYTE_WIDTH-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BCW'(BYTE_WIDTH - 1))
                    rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                par_d      = bus.in;
                rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                done_d     = frame_ok;
                err_d      = !frame_ok;
                rx_state_d = frame_ok ? RX_IDLE : RX_WAIT;
            end
            RX_WAIT: if (bus.in) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A pop on the last sample frees a slot, so a push into a full FIFO still succeeds
    assign sym_last    = mode_q ? BCW'(BYTE_WIDTH / 2 - 1) : BCW'(BYTE_WIDTH - 1);
    assign last_sample = active_q && (k_q == SW'(N - 1)) && (sym_q == sym_last);
    assign pop         = !empty_q && bus.en && (!active_q || last_sample);
    assign push        = done_q && (!full_q || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_byte_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(FIFO_DEPTH));
    end

    always_comb begin
        active_d   = active_q;
        k_d        = k_q;
        sym_d      = sym_q;
        mod_byte_d = mod_byte_q;
        mode_d     = mode_q;
        if (pop) begin
            active_d   = 1'b1;
            k_d        = '0;
            sym_d      = '0;
            mod_byte_d = mem_q[rd_ptr_q];
            mode_d     = bus.mode;
        end else if (active_q) begin
            k_d = k_q + 1'b1;
            if (last_sample) active_d = 1'b0;
            if (k_q == SW'(N - 1)) begin
                sym_d      = sym_q + 1'b1;
                mod_byte_d = mode_q ? (mod_byte_q >> 2) : (mod_byte_q >> 1);
            end
        end
    end

    always_comb begin
        case (mod_byte_q[1:0])
            2'b00:   qtr = 2'(QPSK_Q00);
            2'b01:   qtr = 2'(QPSK_Q01);
            2'b11:   qtr = 2'(QPSK_Q11);
            default: qtr = 2'(QPSK_Q10);
        endcase
        if (mode_q) offset = SW'(int'(qtr) * (N / 4));
        else        offset = mod_byte_q[0] ? '0 : SW'(N / 2);
        rom_addr = k_q + offset;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            rx_byte_q  <= '0;
            par_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            active_q   <= 1'b0;
            k_q        <= '0;
            sym_q      <= '0;
            mod_byte_q <= '0;
            mode_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_byte_q  <= rx_byte_d;
            par_q      <= par_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            active_q   <= active_d;
            k_q        <= k_d;
            sym_q      <= sym_d;
            mod_byte_q <= mod_byte_d;
            mode_q     <= mode_d;
        end
    end

    psk_sine_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N)
    ) u_rom (
        .clk  (clk),
        .rst  (arst),
        .en   (active_q),
        .addr (rom_addr),
        .data (bus.signal_out)
    );

    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.overflow = done_q && full_q && !pop;
    assign bus.busy     = active_q;
endmodule

// File: doc/psk_frame_transceiver.md
# psk_frame_transceiver

Parametrised successor to the transceiver top level. It receives framed serial bytes: start bit, BYTE_WIDTH data bits LSB first, optional even-parity bit, then stop bit. It checks each frame and buffers good bytes in a small FIFO. It drains the FIFO into a selectable BPSK/QPSK sine modulator, so reception and modulation are decoupled and back-to-back bytes produce a continuous waveform.

## Interface
- DATA_WIDTH, 12 — signed output sample width
- BYTE_WIDTH, 8 — payload bits per frame
- FIFO_DEPTH, 4 — byte buffer entries, power of two, ≥ 2
- SAMPLES_PER_SYMBOL, 16 — samples per symbol; one full sine period; multiple of 4
- PARITY_EN, 1 — 1: frame carries even-parity bit; 0: no parity bit

- clk  in  1  sole clock
- arst  in  1  reset, asynchronous, active-high
- in  in  1  serial line, idle high, one bit per clk
- en  in  1  modulator enable
- mode  in  1  0 = BPSK, 1 = QPSK
- done  out  1  one-cycle pulse: good byte received
- err  out  1  one-cycle pulse: parity or stop-bit error
- overflow  out  1  one-cycle pulse: good byte dropped, FIFO full
- busy  out  1  modulator is emitting a byte
- signal_out  out  DATA_WIDTH  signed two's-complement modulated sample

## Operation
- Reset values: all outputs 0; FIFO empty; receiver in IDLE; modulator idle.
- Receiver FSM states and transitions:
  - IDLE: on in=0, go to DATA.
  - DATA: shift BYTE_WIDTH bits, LSB first. Then go to PARITY if PARITY_EN, else STOP.
  - PARITY: store the received parity bit; go to STOP.
  - STOP: if in=1 and parity OK, pulse done, push byte, return to IDLE. Otherwise pulse err and go to WAIT.
  - WAIT: remain until in=1, then go to IDLE. A bad frame never starts a new frame on a low line.
- Parity is even: XOR of the data bits plus the parity bit must equal 0.
- Errored bytes are discarded.
- done and err are never asserted together.
- A good byte arriving while the FIFO is full is dropped; overflow pulses in the same cycle as done.
- Modulator pop: a byte is popped when the FIFO is non-empty, en=1, and the modulator is idle or on the last sample of the current byte.
- mode is latched at pop. Changes to mode mid-byte are ignored.
- Deasserting en stops only future pops; the current byte always completes.
- BPSK: each bit is one symbol. Bit 1 uses phase 0; bit 0 uses phase 180° (ROM address + N/2).
- QPSK: bit pairs (b[2i], b[2i+1]) map Gray-coded to phase offsets: 00→0, 01→90°, 11→180°, 10→270° (address offsets 0, N/4, N/2, 3N/4, mod N). BYTE_WIDTH must be even.
- Sample k of a symbol: ROM[(k + offset) mod N], where N = SAMPLES_PER_SYMBOL.
- ROM content: ROM[k] = round((2^(DATA_WIDTH-1)−1)·sin(2πk/N)).
- While the modulator is idle, signal_out = 0.

## Timing
- The start bit is sampled at cycle t0. Data bits occupy t0+1..t0+BYTE_WIDTH; the parity bit, if present, follows; the stop bit comes at t0+BYTE_WIDTH+1+PARITY_EN.
- done/err/overflow assert in the cycle after the stop bit. The FIFO write happens in that same cycle.
- FIFO empty/full are registered. A byte pushed at cycle w is poppable at w+1 at the earliest.
- Push and pop in the same cycle while full: both succeed, no overflow.
- Pop at cycle p → ROM address at p+1 → first sample on signal_out at p+2. The ROM output is registered.
- busy rises at p+1. It falls after the last sample, unless a back-to-back pop occurs.
- Byte length: BYTE_WIDTH·N cycles in BPSK, BYTE_WIDTH·N/2 in QPSK.
- Back-to-back bytes have no gap.
- arst mid-frame or mid-byte: the receiver and modulator abort immediately, the FIFO is cleared, and signal_out = 0.

## Structure
- Shared package psk_pkg holds:
  - the sine-ROM init function;
  - QPSK Gray-map offset constants;
  - receiver state encodings (IDLE, DATA, PARITY, STOP, WAIT).
- Sub-module psk_sine_rom: N×DATA_WIDTH registered ROM, address log2(N) bits.
- Receiver, FIFO and modulator stay inline.

## Test plan
- BPSK good frame: send 0xA5, parity 0, stop 1, with mode=0, en=1 → done pulses once. signal_out follows symbols 1,0,1,0,0,1,0,1. Symbol 0 sample 4 = +2047; symbol 1 sample 4 = −2047.
- QPSK: byte 0x1B with mode=1 → pairs 11,10,01,00 → first samples of each symbol are ROM[8], ROM[12], ROM[4], ROM[0] = 0, −2047, +2047, 0. Byte lasts 64 cycles.
- Parity error: 0x01 sent with parity bit 0 → err pulse, no done, FIFO stays empty, signal_out stays 0.
- Stop-bit error with line held low for 5 cycles: err pulses, no false start detected, then the next good frame receives correctly.
- Overflow: with en=0, send 5 good bytes → the 5th gives done+overflow. Then raise en → exactly 4 bytes emitted back-to-back, 512 cycles total, no gap.
- arst asserted mid-byte → signal_out=0 and busy=0 the same cycle, FIFO empty. After release, a new frame is received normally.
